// File: rtl/tx3_round_sequencer.sv
// Iterative tx3 round controller: reuses one external combinational round stage for every round of a block.
// Latency: out_valid_o rises ROUND_COUNT clocks after the accept edge; one block per ROUND_COUNT+2 clocks.
// Backpressure: the result is held in DONE until out_ready_i; no new block is accepted until the result is consumed.
module tx3_round_sequencer #(
   parameter int DATA_WIDTH  = 64,
   parameter int ROUND_COUNT = 16,
   parameter int CNT_WIDTH   = 16,
   localparam int IDX_WIDTH  = $clog2(ROUND_COUNT)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic [DATA_WIDTH-1:0] round_data_o,
   output logic [1:0]            round_sel_o,
   output logic [IDX_WIDTH-1:0]  round_idx_o,
   input  logic [DATA_WIDTH-1:0] round_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   input  logic                  flush_i,
   output logic                  busy_o,
   output logic [CNT_WIDTH-1:0]  done_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] SEL_SBOX = 2'd0;
   localparam logic [1:0] SEL_XOR  = 2'd1;
   localparam logic [1:0] SEL_PBOX = 2'd2;

   // Last round index and first round of the trailing PBOX run.
   localparam logic [IDX_WIDTH-1:0] LAST_ROUND  = IDX_WIDTH'(ROUND_COUNT - 1);
   localparam logic [IDX_WIDTH-1:0] PBOX_START  = IDX_WIDTH'(ROUND_COUNT - 3);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_data;
   logic [IDX_WIDTH-1:0]  r_round;
   logic [CNT_WIDTH-1:0]  r_done_count;
   logic                  w_accept;
   logic                  w_deliver;
   logic                  w_last_round;
   logic [1:0]            w_round_sel;

   assign w_last_round = (r_round == LAST_ROUND);

   // State register; reset dominates everything else.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode plus accept/deliver strobes; flush overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_deliver   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid_i) begin
               w_state_nxt = ST_RUN;
               w_accept    = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_last_round) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               w_state_nxt = ST_IDLE;
               w_deliver   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (flush_i) begin
         w_state_nxt = ST_IDLE;
         w_accept    = 1'b0;
         w_deliver   = 1'b0;
      end
   end

   // Block state and round counter: load on accept, take the round stage result each RUN cycle.
   // A flush only rewinds the round counter; the partially processed data is left in place.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_data  <= '0;
         r_round <= '0;
      end else if (flush_i) begin
         r_round <= '0;
      end else if (w_accept) begin
         r_data  <= in_data_i;
         r_round <= '0;
      end else if (r_state == ST_RUN) begin
         r_data  <= round_data_i;
         r_round <= w_last_round ? '0 : r_round + 1'b1;
      end
   end

   // Delivered-block counter, wraps naturally at its width.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_done_count <= '0;
      end else if (w_deliver) begin
         r_done_count <= r_done_count + 1'b1;
      end
   end

   // Round schedule: trailing three rounds are PBOX, otherwise SBOX every fourth round, XOR between.
   always_comb begin
      w_round_sel = SEL_XOR;
      if (r_round >= PBOX_START) begin
         w_round_sel = SEL_PBOX;
      end else if (r_round[1:0] == 2'b00) begin
         w_round_sel = SEL_SBOX;
      end
   end

   assign in_ready_o   = (r_state == ST_IDLE);
   assign out_valid_o  = (r_state == ST_DONE);
   assign busy_o       = (r_state != ST_IDLE);
   assign round_data_o = r_data;
   assign out_data_o   = r_data;
   assign round_sel_o  = w_round_sel;
   assign round_idx_o  = r_round;
   assign done_count_o = r_done_count;

endmodule
